// File: rtl/planning_pkg.sv
// Shared definitions for the planning grid world: direction bit positions,
// turn-scheduler states and the coordinate width.
package planning_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int COORD_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ROBOT = 2'd1,
        ST_ENV   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // True when at most one direction bit is set.
    function automatic logic onehot0(input logic [3:0] dir);
        return (dir & (dir - 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/planning_step.sv
// One-agent move: applies a direction to (x, y), saturating at the grid walls,
// and flags a direction vector with more than one bit set.
module planning_step
    import planning_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [3:0]         dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               illegal
);

    always_comb begin
        next_x  = x;
        next_y  = y;
        illegal = !onehot0(dir);
        // An illegal vector leaves the position untouched; a wall hit is silent.
        if (!illegal) begin
            if (dir[DIR_UP] && (int'(y) < GRID_H - 1))
                next_y = y + COORD_W'(1);
            if (dir[DIR_DOWN] && (int'(y) > 0))
                next_y = y - COORD_W'(1);
            if (dir[DIR_LEFT] && (int'(x) > 0))
                next_x = x - COORD_W'(1);
            if (dir[DIR_RIGHT] && (int'(x) < GRID_W - 1))
                next_x = x + COORD_W'(1);
        end
    end

endmodule

// File: rtl/planning_turn_scheduler.sv
// Grants the move slot to the environment during initialisation, then
// alternates robot and environment turns; illegal moves and collisions latch ERR.
module planning_turn_scheduler
    import planning_pkg::*;
#(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int TURN_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               end_init,
    input  logic [3:0]         robot_dir,
    input  logic [3:0]         obs1_dir,
    input  logic [3:0]         obs2_dir,
    output logic               rt_robot,
    output logic               rt_env,
    output logic [COORD_W-1:0] robot_x,
    output logic [COORD_W-1:0] robot_y,
    output logic [COORD_W-1:0] obs1_x,
    output logic [COORD_W-1:0] obs1_y,
    output logic [COORD_W-1:0] obs2_x,
    output logic [COORD_W-1:0] obs2_y,
    output logic [7:0]         turn_cnt,
    output logic               done,
    output logic               error
);

    state_t state;

    logic [COORD_W-1:0] rob_nx, rob_ny, o1_nx, o1_ny, o2_nx, o2_ny;
    logic               rob_ill, o1_ill, o2_ill;
    logic               o1_on_robot, o2_on_robot, robot_hit;

    planning_step #(.GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W)) u_step_robot (
        .x(robot_x), .y(robot_y), .dir(robot_dir),
        .next_x(rob_nx), .next_y(rob_ny), .illegal(rob_ill)
    );

    planning_step #(.GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W)) u_step_obs1 (
        .x(obs1_x), .y(obs1_y), .dir(obs1_dir),
        .next_x(o1_nx), .next_y(o1_ny), .illegal(o1_ill)
    );

    planning_step #(.GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W)) u_step_obs2 (
        .x(obs2_x), .y(obs2_y), .dir(obs2_dir),
        .next_x(o2_nx), .next_y(o2_ny), .illegal(o2_ill)
    );

    assign o1_on_robot = (o1_nx == robot_x) && (o1_ny == robot_y);
    assign o2_on_robot = (o2_nx == robot_x) && (o2_ny == robot_y);
    assign robot_hit   = ((rob_nx == obs1_x) && (rob_ny == obs1_y)) ||
                         ((rob_nx == obs2_x) && (rob_ny == obs2_y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            robot_x  <= '0;
            robot_y  <= '0;
            obs1_x   <= COORD_W'(GRID_W - 1);
            obs1_y   <= COORD_W'(GRID_H - 1);
            obs2_x   <= COORD_W'(GRID_W - 1);
            obs2_y   <= '0;
            turn_cnt <= 8'd0;
            error    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (o1_ill || o2_ill) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end else begin
                        // During setup an obstacle may not step onto the robot.
                        if (!o1_on_robot) begin
                            obs1_x <= o1_nx;
                            obs1_y <= o1_ny;
                        end
                        if (!o2_on_robot) begin
                            obs2_x <= o2_nx;
                            obs2_y <= o2_ny;
                        end
                        if (end_init)
                            state <= ST_ROBOT;
                    end
                end
                ST_ROBOT: begin
                    if (rob_ill) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end else begin
                        robot_x <= rob_nx;
                        robot_y <= rob_ny;
                        if (robot_hit) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= ST_ENV;
                            if (turn_cnt < 8'(TURN_MAX))
                                turn_cnt <= turn_cnt + 8'd1;
                        end
                    end
                end
                ST_ENV: begin
                    if (o1_ill || o2_ill) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end else begin
                        obs1_x <= o1_nx;
                        obs1_y <= o1_ny;
                        obs2_x <= o2_nx;
                        obs2_y <= o2_ny;
                        if (o1_on_robot || o2_on_robot) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= ST_ROBOT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rt_robot = (state == ST_ROBOT);
    assign rt_env   = (state == ST_INIT) || (state == ST_ENV);
    assign done     = (state != ST_ERR) && (turn_cnt == 8'(TURN_MAX));

endmodule

// File: tb/tb_planning_turn_scheduler.sv
// Bench for planning_turn_scheduler: directed table, hand-written corner
// sequences and random stimulus against a grid-world reference model.
module tb_planning_turn_scheduler;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int CW = 3;
    localparam int TM = 16;

    localparam int M_INIT  = 0;
    localparam int M_ROBOT = 1;
    localparam int M_ENV   = 2;
    localparam int M_ERR   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          end_init;
    logic [3:0]    robot_dir, obs1_dir, obs2_dir;
    logic          rt_robot, rt_env;
    logic [CW-1:0] robot_x, robot_y, obs1_x, obs1_y, obs2_x, obs2_y;
    logic [7:0]    turn_cnt;
    logic          done, error;

    int checks = 0;
    int errors = 0;

    int m_state, m_rx, m_ry, m_o1x, m_o1y, m_o2x, m_o2y, m_tc, m_err;

    typedef struct {
        logic       ei;
        logic [3:0] rd, o1d, o2d;
        int rx, ry, o1x, o1y, o2x, o2y, tc, rr, re, er;
    } vec_t;

    vec_t tbl[11];

    planning_turn_scheduler #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .TURN_MAX(TM)) dut (
        .clk(clk), .rst(rst), .end_init(end_init),
        .robot_dir(robot_dir), .obs1_dir(obs1_dir), .obs2_dir(obs2_dir),
        .rt_robot(rt_robot), .rt_env(rt_env),
        .robot_x(robot_x), .robot_y(robot_y),
        .obs1_x(obs1_x), .obs1_y(obs1_y),
        .obs2_x(obs2_x), .obs2_y(obs2_y),
        .turn_cnt(turn_cnt), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Grid move from the rules: up=y+1, down=y-1, right=x+1, left=x-1, walls stop.
    function automatic void mv(input int x, input int y, input logic [3:0] d,
                               output int nx, output int ny, output int bad);
        nx  = x;
        ny  = y;
        bad = ($countones(d) > 1) ? 1 : 0;
        if (bad == 0) begin
            if (d == 4'b1000) ny = (y + 1 <= GH - 1) ? y + 1 : y;
            if (d == 4'b0100) ny = (y - 1 >= 0) ? y - 1 : y;
            if (d == 4'b0010) nx = (x - 1 >= 0) ? x - 1 : x;
            if (d == 4'b0001) nx = (x + 1 <= GW - 1) ? x + 1 : x;
        end
    endfunction

    task automatic model_reset();
        m_state = M_INIT;
        m_rx = 0;      m_ry = 0;
        m_o1x = GW - 1; m_o1y = GH - 1;
        m_o2x = GW - 1; m_o2y = 0;
        m_tc = 0;
        m_err = 0;
    endtask

    task automatic model_step(input logic ei, input logic [3:0] rd,
                              input logic [3:0] o1d, input logic [3:0] o2d);
        int ax, ay, bx, by, b1, b2;
        if (m_state == M_INIT) begin
            mv(m_o1x, m_o1y, o1d, ax, ay, b1);
            mv(m_o2x, m_o2y, o2d, bx, by, b2);
            if (b1 != 0 || b2 != 0) begin
                m_state = M_ERR; m_err = 1;
            end else begin
                if (!(ax == m_rx && ay == m_ry)) begin m_o1x = ax; m_o1y = ay; end
                if (!(bx == m_rx && by == m_ry)) begin m_o2x = bx; m_o2y = by; end
                if (ei) m_state = M_ROBOT;
            end
        end else if (m_state == M_ROBOT) begin
            mv(m_rx, m_ry, rd, ax, ay, b1);
            if (b1 != 0) begin
                m_state = M_ERR; m_err = 1;
            end else begin
                m_rx = ax; m_ry = ay;
                if ((m_rx == m_o1x && m_ry == m_o1y) || (m_rx == m_o2x && m_ry == m_o2y)) begin
                    m_state = M_ERR; m_err = 1;
                end else begin
                    m_state = M_ENV;
                    if (m_tc < TM) m_tc = m_tc + 1;
                end
            end
        end else if (m_state == M_ENV) begin
            mv(m_o1x, m_o1y, o1d, ax, ay, b1);
            mv(m_o2x, m_o2y, o2d, bx, by, b2);
            if (b1 != 0 || b2 != 0) begin
                m_state = M_ERR; m_err = 1;
            end else begin
                m_o1x = ax; m_o1y = ay; m_o2x = bx; m_o2y = by;
                if ((ax == m_rx && ay == m_ry) || (bx == m_rx && by == m_ry)) begin
                    m_state = M_ERR; m_err = 1;
                end else begin
                    m_state = M_ROBOT;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " robot_x"}, int'(robot_x), m_rx);
        check({tag, " robot_y"}, int'(robot_y), m_ry);
        check({tag, " obs1_x"}, int'(obs1_x), m_o1x);
        check({tag, " obs1_y"}, int'(obs1_y), m_o1y);
        check({tag, " obs2_x"}, int'(obs2_x), m_o2x);
        check({tag, " obs2_y"}, int'(obs2_y), m_o2y);
        check({tag, " turn_cnt"}, int'(turn_cnt), m_tc);
        check({tag, " error"}, int'(error), m_err);
        check({tag, " rt_robot"}, int'(rt_robot), (m_state == M_ROBOT) ? 1 : 0);
        check({tag, " rt_env"}, int'(rt_env), (m_state == M_INIT || m_state == M_ENV) ? 1 : 0);
        check({tag, " done"}, int'(done), (m_state != M_ERR && m_tc == TM) ? 1 : 0);
    endtask

    task automatic drive_cycle(input string tag, input logic ei, input logic [3:0] rd,
                               input logic [3:0] o1d, input logic [3:0] o2d);
        end_init  = ei;
        robot_dir = rd;
        obs1_dir  = o1d;
        obs2_dir  = o2d;
        @(posedge clk);
        model_step(ei, rd, o1d, o2d);
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        end_init = 1'b0; robot_dir = 4'd0; obs1_dir = 4'd0; obs2_dir = 4'd0;
        rst = 1'b1;
        #2;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_dir();
        int k;
        logic [3:0] d;
        k = $urandom_range(0, 19);
        if (k == 0) begin
            d = 4'b0011 << $urandom_range(0, 2);
            d = d | 4'($urandom_range(0, 15));
        end else if (k < 5) begin
            d = 4'd0;
        end else begin
            d = 4'b0001 << $urandom_range(0, 3);
        end
        return d;
    endfunction

    function automatic vec_t mk(input logic ei, input logic [3:0] rd, input logic [3:0] o1d,
                                input int rx, input int ry, input int o1x, input int tc,
                                input int rr, input int re);
        vec_t v;
        v.ei = ei; v.rd = rd; v.o1d = o1d; v.o2d = 4'd0;
        v.rx = rx; v.ry = ry; v.o1x = o1x; v.o1y = 7; v.o2x = 7; v.o2y = 0;
        v.tc = tc; v.rr = rr; v.re = re; v.er = 0;
        return v;
    endfunction

    initial begin
        // INIT moves obs1 left while robot_dir is ignored, then four robot turns upward.
        tbl[0]  = mk(1'b0, 4'b1000, 4'b0010, 0, 0, 6, 0, 0, 1);
        tbl[1]  = mk(1'b0, 4'b1000, 4'b0010, 0, 0, 5, 0, 0, 1);
        tbl[2]  = mk(1'b0, 4'b1000, 4'b0010, 0, 0, 4, 0, 0, 1);
        tbl[3]  = mk(1'b1, 4'b0000, 4'b0000, 0, 0, 4, 0, 1, 0);
        tbl[4]  = mk(1'b0, 4'b1000, 4'b0000, 0, 1, 4, 1, 0, 1);
        tbl[5]  = mk(1'b0, 4'b0000, 4'b0000, 0, 1, 4, 1, 1, 0);
        tbl[6]  = mk(1'b0, 4'b1000, 4'b0000, 0, 2, 4, 2, 0, 1);
        tbl[7]  = mk(1'b0, 4'b0000, 4'b0000, 0, 2, 4, 2, 1, 0);
        tbl[8]  = mk(1'b0, 4'b1000, 4'b0000, 0, 3, 4, 3, 0, 1);
        tbl[9]  = mk(1'b0, 4'b0000, 4'b0000, 0, 3, 4, 3, 1, 0);
        tbl[10] = mk(1'b0, 4'b1000, 4'b0000, 0, 4, 4, 4, 0, 1);

        rst = 1'b1;
        end_init = 1'b0; robot_dir = 4'd0; obs1_dir = 4'd0; obs2_dir = 4'd0;
        apply_reset();

        for (int i = 0; i < 11; i++) begin
            end_init = tbl[i].ei; robot_dir = tbl[i].rd;
            obs1_dir = tbl[i].o1d; obs2_dir = tbl[i].o2d;
            @(posedge clk);
            model_step(tbl[i].ei, tbl[i].rd, tbl[i].o1d, tbl[i].o2d);
            #1;
            check($sformatf("tbl%0d robot_x", i), int'(robot_x), tbl[i].rx);
            check($sformatf("tbl%0d robot_y", i), int'(robot_y), tbl[i].ry);
            check($sformatf("tbl%0d obs1_x", i), int'(obs1_x), tbl[i].o1x);
            check($sformatf("tbl%0d obs1_y", i), int'(obs1_y), tbl[i].o1y);
            check($sformatf("tbl%0d obs2_x", i), int'(obs2_x), tbl[i].o2x);
            check($sformatf("tbl%0d obs2_y", i), int'(obs2_y), tbl[i].o2y);
            check($sformatf("tbl%0d turn_cnt", i), int'(turn_cnt), tbl[i].tc);
            check($sformatf("tbl%0d rt_robot", i), int'(rt_robot), tbl[i].rr);
            check($sformatf("tbl%0d rt_env", i), int'(rt_env), tbl[i].re);
            check($sformatf("tbl%0d error", i), int'(error), tbl[i].er);
            check($sformatf("tbl%0d done", i), int'(done), 0);
        end

        // Wall: robot at origin moving down stays put without error.
        apply_reset();
        drive_cycle("wall start", 1'b1, 4'd0, 4'd0, 4'd0);
        drive_cycle("wall", 1'b0, 4'b0100, 4'd0, 4'd0);
        check("wall robot_y", int'(robot_y), 0);
        check("wall error", int'(error), 0);
        check("wall rt_env", int'(rt_env), 1);

        // Illegal robot dir latches ERR; later inputs change nothing.
        apply_reset();
        drive_cycle("illegal start", 1'b1, 4'd0, 4'd0, 4'd0);
        drive_cycle("illegal", 1'b0, 4'b1010, 4'd0, 4'd0);
        check("illegal error", int'(error), 1);
        check("illegal rt_robot", int'(rt_robot), 0);
        check("illegal rt_env", int'(rt_env), 0);
        check("illegal robot_x", int'(robot_x), 0);
        for (int i = 0; i < 3; i++)
            drive_cycle("err frozen", 1'b1, 4'b1000, 4'b0010, 4'b0010);
        check("frozen robot_y", int'(robot_y), 0);
        check("frozen obs1_x", int'(obs1_x), 7);
        check("frozen error", int'(error), 1);

        // Collision in ENV: robot walks to (6,7), obs1 steps left onto it.
        apply_reset();
        drive_cycle("coll start", 1'b1, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 13; i++) begin
            drive_cycle("coll walk", 1'b0, (i < 7) ? 4'b1000 : 4'b0001, 4'd0, 4'd0);
            if (i < 12)
                drive_cycle("coll idle", 1'b0, 4'd0, 4'd0, 4'd0);
        end
        check("coll robot_x", int'(robot_x), 6);
        check("coll robot_y", int'(robot_y), 7);
        drive_cycle("coll hit", 1'b0, 4'd0, 4'b0010, 4'd0);
        check("coll obs1_x", int'(obs1_x), 6);
        check("coll error", int'(error), 1);
        check("coll done", int'(done), 0);

        // INIT suppression: obs2 slides left but cannot enter the robot cell.
        apply_reset();
        for (int i = 0; i < 7; i++)
            drive_cycle("init supp", 1'b0, 4'd0, 4'd0, 4'b0010);
        check("init supp obs2_x", int'(obs2_x), 1);
        check("init supp error", int'(error), 0);

        // Saturation, then asynchronous reset in the middle of an ENV turn.
        apply_reset();
        drive_cycle("sat start", 1'b1, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < TM + 3; i++) begin
            drive_cycle("sat robot", 1'b0, 4'd0, 4'd0, 4'd0);
            drive_cycle("sat env", 1'b0, 4'd0, 4'd0, 4'd0);
        end
        check("sat turn_cnt", int'(turn_cnt), 16);
        check("sat done", int'(done), 1);
        drive_cycle("sat to env", 1'b0, 4'd0, 4'd0, 4'd0);
        check("sat in env", int'(rt_env), 1);
        rst = 1'b1;
        #1;
        check("async robot_x", int'(robot_x), 0);
        check("async obs1_x", int'(obs1_x), 7);
        check("async obs1_y", int'(obs1_y), 7);
        check("async obs2_x", int'(obs2_x), 7);
        check("async obs2_y", int'(obs2_y), 0);
        check("async turn_cnt", int'(turn_cnt), 0);
        check("async done", int'(done), 0);
        check("async rt_env", int'(rt_env), 1);
        check("async rt_robot", int'(rt_robot), 0);
        check("async error", int'(error), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random episodes against the reference model.
        for (int ep = 0; ep < 25; ep++) begin
            apply_reset();
            for (int c = 0; c < 60; c++)
                drive_cycle("rand", ($urandom_range(0, 7) == 0), rand_dir(), rand_dir(), rand_dir());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
